// File: rtl/vector_mem_sequencer.sv
// -----------------------------------------------------------------------------
// vector_mem_sequencer
//
// Sequences a vector load (VLD) or vector store (VST) through the single
// ELEM_W-bit data-memory port, one element per accepted handshake. The
// instruction fields are snapshotted on start. When the instruction finishes,
// the block pulses done, and it also pulses vec_we for loads.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      begin an instruction (sampled in IDLE only)
//   functype   4'b0100 = VLD, 4'b0101 = VST, other codes ignored
//   base       scalar base address
//   offset     6-bit signed immediate offset
//   vec_in     store vector, element 0 in the low bits
//   busy       high while an instruction is in ACCESS or DONE
//   done       one-cycle completion pulse
//   vec_we     load write-back strobe, coincident with done for VLD
//   vec_out    assembled load vector
//   mem_addr   element address (0 when no request is active)
//   mem_re     read request
//   mem_we     write request
//   mem_wdata  store element
//   mem_rdata  load element, valid in the mem_ready cycle
//   mem_ready  memory accepts/completes the current request
// -----------------------------------------------------------------------------
module vector_mem_sequencer #(
    parameter int ELEMS  = 16,
    parameter int ELEM_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [3:0]               functype,
    input  logic [15:0]              base,
    input  logic [5:0]               offset,
    input  logic [ELEMS*ELEM_W-1:0]  vec_in,
    output logic                     busy,
    output logic                     done,
    output logic                     vec_we,
    output logic [ELEMS*ELEM_W-1:0]  vec_out,
    output logic [15:0]              mem_addr,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [ELEM_W-1:0]        mem_wdata,
    input  logic [ELEM_W-1:0]        mem_rdata,
    input  logic                     mem_ready
);

    localparam int IDX_W = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam logic [3:0] FT_VLD = 4'b0100;
    localparam logic [3:0] FT_VST = 4'b0101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           idx_nxt;
    logic [15:0]                ea;
    logic [15:0]                ea_start;
    logic                       is_st;
    logic                       start_ok;
    logic [ELEMS*ELEM_W-1:0]    snap;

    always_comb begin
        idx_nxt  = idx + IDX_W'(1);
        // Sign-extend the offset; the sum wraps mod 2^16.
        ea_start = base + {{10{offset[5]}}, offset};
        start_ok = start && ((functype == FT_VLD) || (functype == FT_VST));
    end

    // Request outputs are preloaded one cycle ahead (on start or on the
    // accepting handshake), so they never depend combinationally on mem_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            ea        <= '0;
            is_st     <= 1'b0;
            snap      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            vec_we    <= 1'b0;
            vec_out   <= '0;
            mem_addr  <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        is_st     <= (functype == FT_VST);
                        ea        <= ea_start;
                        snap      <= vec_in;
                        idx       <= '0;
                        mem_addr  <= ea_start;
                        mem_re    <= (functype == FT_VLD);
                        mem_we    <= (functype == FT_VST);
                        mem_wdata <= vec_in[ELEM_W-1:0];
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        if (!is_st) begin
                            vec_out[int'(idx)*ELEM_W +: ELEM_W] <= mem_rdata;
                        end
                        if (idx == IDX_W'(ELEMS - 1)) begin
                            mem_re   <= 1'b0;
                            mem_we   <= 1'b0;
                            mem_addr <= '0;
                            done     <= 1'b1;
                            vec_we   <= !is_st;
                            state    <= DONE;
                        end else begin
                            idx       <= idx_nxt;
                            mem_addr  <= ea + 16'(idx_nxt);
                            mem_wdata <= snap[int'(idx_nxt)*ELEM_W +: ELEM_W];
                        end
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    vec_we <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
module tb_vector_mem_sequencer;

    localparam int ELEMS  = 16;
    localparam int ELEM_W = 16;
    localparam int VW     = ELEMS * ELEM_W;
    localparam logic [3:0] VLD = 4'b0100;
    localparam logic [3:0] VST = 4'b0101;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] data;
    } acc_t;

    typedef struct {
        logic          vec_we;
        logic [VW-1:0] vec;
        int            cyc;
    } done_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    functype = 4'd0;
    logic [15:0]   base = 16'd0;
    logic [5:0]    offset = 6'd0;
    logic [VW-1:0] vec_in = '0;
    logic          busy;
    logic          done;
    logic          vec_we;
    logic [VW-1:0] vec_out;
    logic [15:0]   mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata = 16'd0;
    logic          mem_ready = 1'b0;

    vector_mem_sequencer #(.ELEMS(ELEMS), .ELEM_W(ELEM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .functype  (functype),
        .base      (base),
        .offset    (offset),
        .vec_in    (vec_in),
        .busy      (busy),
        .done      (done),
        .vec_we    (vec_we),
        .vec_out   (vec_out),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ready_mode = 0;   // 0: always ready, 1: alternate starting not-ready, 2: random

    logic [15:0]   mem     [0:65535];   // memory seen by the DUT
    logic [15:0]   ref_mem [0:65535];   // reference model memory
    logic [VW-1:0] exp_vec = '0;        // reference model of vec_out
    acc_t          exp_acc[$];
    done_t         exp_done[$];

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference model: an instruction is a list of element accesses at
    // consecutive addresses from base+offset, followed by one completion.
    task automatic model_issue(input logic [3:0] ft, input logic [15:0] b, input logic [5:0] off,
                               input logic [VW-1:0] v, input int cyc);
        acc_t  a;
        done_t d;
        int    ea;
        logic  st;
        if (ft != VLD && ft != VST) return;
        st = (ft == VST);
        ea = int'(b) + int'($signed(off));
        for (int i = 0; i < ELEMS; i++) begin
            a.addr = 16'((ea + i) % 65536);
            a.we   = st;
            a.data = v[i*ELEM_W +: ELEM_W];
            exp_acc.push_back(a);
            if (st) ref_mem[a.addr] = a.data;
            else    exp_vec[i*ELEM_W +: ELEM_W] = ref_mem[a.addr];
        end
        d.vec_we = !st;
        d.vec    = exp_vec;
        d.cyc    = cyc;
        exp_done.push_back(d);
    endtask

    // Memory responder and scoreboard monitor.
    int   acc_cyc = 0;
    logic alt = 1'b0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        logic  req;
        logic  rdy;
        acc_t  a;
        done_t d;
        req = mem_re | mem_we;
        if (!rst_n) begin
            acc_cyc   = 0;
            alt       = 1'b0;
            prev_done = 1'b0;
            mem_ready = 1'b0;
        end else begin
            if (req) begin
                case (ready_mode)
                    0:       rdy = 1'b1;
                    1:       begin rdy = alt; alt = !alt; end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                acc_cyc++;
                chk("re_we_exclusive", mem_re & mem_we, 0);
            end else begin
                rdy = 1'b0;
                alt = 1'b0;
                chk("idle_addr", mem_addr, 0);
            end
            mem_ready = rdy;
            mem_rdata = rdy ? mem[mem_addr] : 16'($urandom);
            if (rdy) begin
                if (exp_acc.size() == 0) begin
                    chk("unexpected_req", req, 0);
                end else begin
                    a = exp_acc.pop_front();
                    chk("acc_addr", mem_addr, a.addr);
                    chk("acc_we", mem_we, a.we);
                    chk("acc_re", mem_re, !a.we);
                    if (a.we) chk("acc_wdata", mem_wdata, a.data);
                end
                if (mem_we) mem[mem_addr] = mem_wdata;
            end
            if (done) begin
                chk("done_one_cycle", prev_done, 0);
                chk("done_busy", busy, 1);
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", done, 0);
                end else begin
                    d = exp_done.pop_front();
                    chk("vec_we", vec_we, d.vec_we);
                    chk("vec_out", vec_out, d.vec);
                    if (d.cyc >= 0) chk("access_cycles", acc_cyc, d.cyc);
                end
                acc_cyc = 0;
            end else begin
                chk("vec_we_without_done", vec_we, 0);
            end
            prev_done = done;
        end
    end

    // Issue one instruction (called just after a falling edge) and wait for it.
    task automatic run_op(input logic [3:0] ft, input logic [15:0] b, input logic [5:0] off,
                          input logic [VW-1:0] v, input int mode, input bit midstart);
        int lat;
        int cyc;
        cyc = (mode == 0) ? 16 : (mode == 1) ? 32 : -1;
        ready_mode = mode;
        start    = 1'b1;
        functype = ft;
        base     = b;
        offset   = off;
        vec_in   = v;
        model_issue(ft, b, off, v, cyc);
        if (ft != VLD && ft != VST) begin
            repeat (4) begin
                @(negedge clk);
                start = 1'b0;
                chk("ignored_busy", busy, 0);
            end
            return;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (lat == 1) begin
                chk("first_req", mem_re | mem_we, 1);
                chk("busy_first", busy, 1);
            end
            if (midstart && lat == 5) begin
                start    = 1'b1;
                functype = ($urandom_range(0, 1) != 0) ? VLD : VST;
            end
            base   = 16'($urandom);
            offset = 6'($urandom);
            vec_in = rand_vec();
        end while (!done && lat < 400);
        if (!done) chk("done_timeout", done, 1);
        else if (mode == 0) chk("latency", lat, 17);
        @(negedge clk);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic reset_midop();
        ready_mode = 0;
        start    = 1'b1;
        functype = VLD;
        base     = 16'($urandom);
        offset   = 6'($urandom);
        model_issue(VLD, base, offset, '0, 16);
        repeat (7) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_vec_out", vec_out, 0);
        exp_vec = '0;
        exp_acc.delete();
        exp_done.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
    endtask

    task automatic back_to_back();
        logic [15:0]   b;
        logic [5:0]    off;
        logic [VW-1:0] v;
        int            lat;
        b   = 16'($urandom);
        off = 6'($urandom);
        v   = rand_vec();
        ready_mode = 0;
        start    = 1'b1;
        functype = VST;
        base     = b;
        offset   = off;
        vec_in   = v;
        model_issue(VST, b, off, v, 16);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 400);
        if (!done) chk("b2b_st_timeout", done, 1);
        else chk("b2b_st_latency", lat, 17);
        functype = VLD;
        model_issue(VLD, b, off, '0, 16);
        @(negedge clk);
        chk("b2b_gap_busy", busy, 0);
        @(negedge clk);
        chk("b2b_second_busy", busy, 1);
        chk("b2b_second_re", mem_re, 1);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        if (!done) chk("b2b_ld_timeout", done, 1);
        @(negedge clk);
        chk("b2b_readback", vec_out, v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [VW-1:0] v;
        for (int a = 0; a < 65536; a++) begin
            mem[a]     = 16'(a) ^ 16'hA5A5;
            ref_mem[a] = 16'(a) ^ 16'hA5A5;
        end
        repeat (2) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_vec_we", vec_we, 0);
        chk("reset_mem_re", mem_re, 0);
        chk("reset_mem_we", mem_we, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_mem_wdata", mem_wdata, 0);
        chk("reset_vec_out", vec_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait load at base 0x0100, offset -2.
        run_op(VLD, 16'h0100, 6'b111110, rand_vec(), 0, 1'b0);
        chk("vld_elem0", vec_out[15:0], 16'h00FE ^ 16'hA5A5);
        chk("vld_elem15", vec_out[255:240], 16'h010D ^ 16'hA5A5);

        // Store with a wait state on every other cycle.
        for (int i = 0; i < ELEMS; i++) v[i*ELEM_W +: ELEM_W] = 16'h1000 + 16'(i);
        run_op(VST, 16'h0000, 6'd5, v, 1, 1'b0);

        // Address wrap-around, random ready.
        run_op(VLD, 16'hFFFA, 6'd3, rand_vec(), 2, 1'b0);
        run_op(VST, 16'hFFFA, 6'd3, rand_vec(), 0, 1'b0);

        // Non-memory opcodes are ignored.
        run_op(4'b0001, 16'($urandom), 6'($urandom), rand_vec(), 0, 1'b0);
        run_op(4'b1111, 16'($urandom), 6'($urandom), rand_vec(), 0, 1'b0);

        // start pulsed mid-operation is not queued.
        run_op(VLD, 16'($urandom), 6'($urandom), rand_vec(), 0, 1'b1);
        run_op(VST, 16'($urandom), 6'($urandom), rand_vec(), 1, 1'b1);

        // Reset in the middle of a load, then a clean load.
        reset_midop();
        run_op(VLD, 16'($urandom), 6'($urandom), rand_vec(), 0, 1'b0);

        back_to_back();

        for (int n = 0; n < 12; n++) begin
            run_op(($urandom_range(0, 1) != 0) ? VLD : VST, 16'($urandom), 6'($urandom),
                   rand_vec(), int'($urandom_range(0, 2)), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("leftover_acc", exp_acc.size(), 0);
        chk("leftover_done", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
